// File: rtl/counter_7seg_if.sv
// ============================================================================
// Module      : counter_7seg_if
// Description : Display bus carrying the two-digit active-low 7-segment code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface counter_7seg_if;
  // {units_seg[6:0], tens_seg[6:0]}, bit order {g,f,e,d,c,b,a}, 0 = lit
  logic [13:0] result;

  modport master (output result);
  modport slave  (input  result);
endinterface

`default_nettype wire

// File: rtl/counter_7seg.sv
// ============================================================================
// Module      : counter_7seg
// Description : Free-running wrap-around up-counter shown as two decimal
//               digits on active-low 7-segment displays, leading zero blanked.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_7seg #(
  parameter int WIDTH = 2
) (
  input  wire              clk,
  input  wire              rst,
  counter_7seg_if.master   bus
);

  localparam logic [WIDTH-1:0] c_one   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [6:0]       c_blank = 7'b1111111;
  localparam logic [6:0]       c_ten   = 7'd10;

  logic [WIDTH-1:0] r_cnt;
  logic [6:0]       w_val;
  logic [3:0]       w_units;
  logic [3:0]       w_tens;

  function automatic logic [6:0] seg(input logic [3:0] digit);
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = c_blank;
    endcase
  endfunction

  // Natural modulo-2**WIDTH wrap of the adder provides the rollover.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_one;
    end
  end

  // Widen to 7 bits so the decimal split is uniform for every legal WIDTH.
  assign w_val   = {{(7-WIDTH){1'b0}}, r_cnt};
  assign w_units = 4'(w_val % c_ten);
  assign w_tens  = 4'(w_val / c_ten);

  assign bus.result = {seg(w_units), (w_tens == 4'd0) ? c_blank : seg(w_tens)};

endmodule

`default_nettype wire

// File: tb/tb_counter_7seg.sv
// ============================================================================
// Module      : tb_counter_7seg
// Description : Directed bench for counter_7seg at WIDTH=2 and WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_7seg;

  logic clk = 1'b0;
  logic rst2;
  logic rst4;
  int   tests = 0;
  int   fails = 0;

  counter_7seg_if bus2 ();
  counter_7seg_if bus4 ();

  counter_7seg #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst2), .bus(bus2.master));
  counter_7seg #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(bus4.master));

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [13:0] exp;
  } vec_t;

  vec_t        w2_tbl[15];
  logic [13:0] w4_exp[16];

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // WIDTH=2: reset, count, wrap, mid-count reset, held reset
    w2_tbl[0]  = '{1'b1, 14'b1000000_1111111};
    w2_tbl[1]  = '{1'b0, 14'b1111001_1111111};
    w2_tbl[2]  = '{1'b0, 14'b0100100_1111111};
    w2_tbl[3]  = '{1'b0, 14'b0110000_1111111};
    w2_tbl[4]  = '{1'b0, 14'b1000000_1111111};
    w2_tbl[5]  = '{1'b0, 14'b1111001_1111111};
    w2_tbl[6]  = '{1'b0, 14'b0100100_1111111};
    w2_tbl[7]  = '{1'b1, 14'b1000000_1111111};
    w2_tbl[8]  = '{1'b0, 14'b1111001_1111111};
    w2_tbl[9]  = '{1'b0, 14'b0100100_1111111};
    w2_tbl[10] = '{1'b1, 14'b1000000_1111111};
    w2_tbl[11] = '{1'b1, 14'b1000000_1111111};
    w2_tbl[12] = '{1'b1, 14'b1000000_1111111};
    w2_tbl[13] = '{1'b0, 14'b1111001_1111111};
    w2_tbl[14] = '{1'b0, 14'b0100100_1111111};

    w4_exp[0]  = 14'b1000000_1111111;
    w4_exp[1]  = 14'b1111001_1111111;
    w4_exp[2]  = 14'b0100100_1111111;
    w4_exp[3]  = 14'b0110000_1111111;
    w4_exp[4]  = 14'b0011001_1111111;
    w4_exp[5]  = 14'b0010010_1111111;
    w4_exp[6]  = 14'b0000010_1111111;
    w4_exp[7]  = 14'b1111000_1111111;
    w4_exp[8]  = 14'b0000000_1111111;
    w4_exp[9]  = 14'b0010000_1111111;
    w4_exp[10] = 14'b1000000_1111001;
    w4_exp[11] = 14'b1111001_1111001;
    w4_exp[12] = 14'b0100100_1111001;
    w4_exp[13] = 14'b0110000_1111001;
    w4_exp[14] = 14'b0011001_1111001;
    w4_exp[15] = 14'b0010010_1111001;

    rst2 = 1'b1;
    rst4 = 1'b1;

    for (int i = 0; i < 15; i++) begin
      rst2 = w2_tbl[i].rst;
      step();
      check($sformatf("w2_vec%0d", i), bus2.result, w2_tbl[i].exp);
    end

    // rst4 was held high throughout the WIDTH=2 run
    check("w4_held_reset", bus4.result, w4_exp[0]);

    rst4 = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      check($sformatf("w4_count%0d", i), bus4.result, w4_exp[i]);
    end
    step();
    check("w4_wrap", bus4.result, w4_exp[0]);

    // Reset from count 12 with a single edge, then resume counting
    for (int i = 0; i < 12; i++) step();
    check("w4_pre_rst12", bus4.result, w4_exp[12]);
    rst4 = 1'b1;
    step();
    check("w4_mid_rst", bus4.result, w4_exp[0]);
    rst4 = 1'b0;
    step();
    check("w4_resume1", bus4.result, w4_exp[1]);
    step();
    check("w4_resume2", bus4.result, w4_exp[2]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
